// File: rtl/queue_arbiter_pkg.sv
// Shared types and constants for the queue arbiter: FSM state encoding,
// byte width and the default queue depth.
package queue_arbiter_pkg;

  localparam int DATA_W        = 8;
  localparam int DEFAULT_DEPTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENQ      = 3'd1,
    ST_ENQ_WAIT = 3'd2,
    ST_DEQ      = 3'd3,
    ST_DEQ_WAIT = 3'd4
  } state_e;

endpackage

// File: rtl/queue_arbiter_rr_picker.sv
// rr_picker: rotating priority encoder; the search starts just after ptr
// and wraps modulo N, returning both a one-hot pick and its index.
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic          found_s;
  logic [IW-1:0] cand_s;

  // First requester at or after ptr+1 (wrapping) wins.
  always_comb begin
    pick    = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 1; i <= N; i++) begin
      cand_s = IW'((int'(ptr) + i) % N);
      if (!found_s && req[cand_s]) begin
        found_s      = 1'b1;
        pick[cand_s] = 1'b1;
        idx          = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/queue_arbiter.sv
// queue_arbiter: serialises N_REQ producers and one consumer onto a single queue port.
// Optional build macro QARB_FIXED_PRIO0_EN gives requester 0 absolute priority.
module queue_arbiter
  import queue_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                    clk_10khz,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_grant,
  input  logic                    deq_req,
  output logic                    deq_valid,
  output logic [DATA_W-1:0]       deq_data,
  output logic                    q_enqueue,
  output logic                    q_dequeue,
  output logic [DATA_W-1:0]       q_data,
  input  logic                    q_ack,
  input  logic [3:0]              q_len,
  input  logic [DATA_W-1:0]       q_data_out,
  output logic                    busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e              state_q, state_d;
  logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]       winner_q, winner_d;
  logic                last_was_deq_q, last_was_deq_d;
  logic [N_REQ-1:0]    req_grant_q, req_grant_d;
  logic                deq_valid_q, deq_valid_d;
  logic [DATA_W-1:0]   deq_data_q, deq_data_d;
  logic                q_enqueue_q, q_enqueue_d;
  logic                q_dequeue_q, q_dequeue_d;
  logic [DATA_W-1:0]   q_data_q, q_data_d;
  logic                busy_q, busy_d;

  logic [N_REQ-1:0]    rr_req_s;
  logic [N_REQ-1:0]    pick_s;
  logic [IW-1:0]       pick_idx_s;
  logic [IW-1:0]       sel_idx_s;
  logic                enq_any_s;
  logic                enq_elig_s;
  logic                deq_elig_s;

`ifdef QARB_FIXED_PRIO0_EN
  // Requester 0 bypasses the rotation; the rest share the round-robin.
  assign rr_req_s  = {req_valid[N_REQ-1:1], 1'b0};
  assign enq_any_s = req_valid[0] | (|pick_s);
  assign sel_idx_s = req_valid[0] ? '0 : pick_idx_s;
`else
  assign rr_req_s  = req_valid;
  assign enq_any_s = |pick_s;
  assign sel_idx_s = pick_idx_s;
`endif

  rr_picker #(.N(N_REQ), .IW(IW)) u_picker (
    .req  (rr_req_s),
    .ptr  (rr_ptr_q),
    .pick (pick_s),
    .idx  (pick_idx_s)
  );

  assign enq_elig_s = enq_any_s && (int'(q_len) < DEPTH);
  assign deq_elig_s = deq_req && (q_len != 4'd0);

  // Next-state and registered-output values; pulses default low.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    winner_d       = winner_q;
    last_was_deq_d = last_was_deq_q;
    req_grant_d    = '0;
    deq_valid_d    = 1'b0;
    deq_data_d     = deq_data_q;
    q_enqueue_d    = 1'b0;
    q_dequeue_d    = 1'b0;
    q_data_d       = q_data_q;
    case (state_q)
      ST_IDLE: begin
        if (deq_elig_s && (!enq_elig_s || !last_was_deq_q)) begin
          state_d        = ST_DEQ;
          q_dequeue_d    = 1'b1;
          last_was_deq_d = 1'b1;
        end else if (enq_elig_s) begin
          state_d        = ST_ENQ;
          winner_d       = sel_idx_s;
          q_enqueue_d    = 1'b1;
          q_data_d       = req_data[{sel_idx_s, 3'b000} +: DATA_W];
          last_was_deq_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ENQ:      state_d = ST_ENQ_WAIT;
      ST_ENQ_WAIT: begin
        state_d = ST_IDLE;
        if (q_ack) begin
          req_grant_d[winner_q] = 1'b1;
          rr_ptr_d              = winner_q;
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      ST_DEQ:      state_d = ST_DEQ_WAIT;
      ST_DEQ_WAIT: begin
        state_d     = ST_IDLE;
        deq_valid_d = 1'b1;
        deq_data_d  = q_data_out;
      end
      default:     state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_10khz) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= IW'(N_REQ - 1);
      winner_q       <= '0;
      last_was_deq_q <= 1'b0;
      req_grant_q    <= '0;
      deq_valid_q    <= 1'b0;
      deq_data_q     <= '0;
      q_enqueue_q    <= 1'b0;
      q_dequeue_q    <= 1'b0;
      q_data_q       <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      winner_q       <= winner_d;
      last_was_deq_q <= last_was_deq_d;
      req_grant_q    <= req_grant_d;
      deq_valid_q    <= deq_valid_d;
      deq_data_q     <= deq_data_d;
      q_enqueue_q    <= q_enqueue_d;
      q_dequeue_q    <= q_dequeue_d;
      q_data_q       <= q_data_d;
      busy_q         <= busy_d;
    end
  end

  assign req_grant = req_grant_q;
  assign deq_valid = deq_valid_q;
  assign deq_data  = deq_data_q;
  assign q_enqueue = q_enqueue_q;
  assign q_dequeue = q_dequeue_q;
  assign q_data    = q_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_queue_arbiter.sv
// Self-checking bench for queue_arbiter: a behavioural queue, a transaction-level
// reference model, directed scenarios and a randomized phase.
`timescale 1us/1ns
module tb_queue_arbiter;

  localparam int N     = 4;
  localparam int DEPTH = 8;

  logic          clk_10khz = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  req_grant;
  logic          deq_req;
  logic          deq_valid;
  logic [7:0]    deq_data;
  logic          q_enqueue;
  logic          q_dequeue;
  logic [7:0]    q_data;
  logic          q_ack;
  logic [3:0]    q_len;
  logic [7:0]    q_data_out;
  logic          busy;

  always #50 clk_10khz = ~clk_10khz;

  queue_arbiter #(.N_REQ(N), .DEPTH(DEPTH)) dut (
    .clk_10khz (clk_10khz),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_grant (req_grant),
    .deq_req   (deq_req),
    .deq_valid (deq_valid),
    .deq_data  (deq_data),
    .q_enqueue (q_enqueue),
    .q_dequeue (q_dequeue),
    .q_data    (q_data),
    .q_ack     (q_ack),
    .q_len     (q_len),
    .q_data_out(q_data_out),
    .busy      (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Environment queue
  logic [7:0] env_q[$];
  int         force_len  = -1;
  bit         accept_all = 1'b1;

  // Reference model: an operation occupies 3 cycles (start, wait, finish)
  int         m_phase;
  bit         m_kind_deq;
  int         m_win;
  int         m_ptr;
  bit         m_last_deq;
  logic [7:0] m_qbyte;
  logic [7:0] m_bytes[$];

  logic [N-1:0] e_grant;
  logic         e_deq_valid, e_q_enq, e_q_deq, e_busy;
  logic [7:0]   e_deq_data, e_q_data;
  bit           chk_qdata, chk_deq;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] rv, input int ptr);
    int k;
`ifdef QARB_FIXED_PRIO0_EN
    if (rv[0]) return 0;
`endif
    for (int i = 1; i <= N; i++) begin
      k = (ptr + i) % N;
      if (rv[k]) return k;
    end
    return 0;
  endfunction

  task automatic upd_len();
    q_len = (force_len >= 0) ? 4'(force_len) : 4'(env_q.size());
  endtask

  task automatic model_step();
    bit enq_el, deq_el;
    e_grant = '0; e_deq_valid = 1'b0; e_q_enq = 1'b0; e_q_deq = 1'b0;
    chk_qdata = 1'b0; chk_deq = 1'b0;
    if (reset) begin
      m_phase = 0; m_ptr = N - 1; m_last_deq = 1'b0; m_win = 0;
      e_busy = 1'b0; e_q_data = 8'h00; e_deq_data = 8'h00;
      chk_qdata = 1'b1; chk_deq = 1'b1;
      m_bytes.delete();
    end else if (m_phase == 0) begin
      enq_el = (req_valid != '0) && (int'(q_len) < DEPTH);
      deq_el = deq_req && (q_len != 4'd0);
      e_busy = 1'b1;
      if (deq_el && (!enq_el || !m_last_deq)) begin
        m_phase = 1; m_kind_deq = 1'b1; m_last_deq = 1'b1; e_q_deq = 1'b1;
      end else if (enq_el) begin
        m_win = rr_pick(req_valid, m_ptr);
        m_qbyte = req_data[m_win*8 +: 8];
        m_phase = 1; m_kind_deq = 1'b0; m_last_deq = 1'b0;
        e_q_enq = 1'b1; e_q_data = m_qbyte; chk_qdata = 1'b1;
      end else begin
        e_busy = 1'b0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2; e_busy = 1'b1;
    end else begin
      m_phase = 0; e_busy = 1'b0;
      if (m_kind_deq) begin
        e_deq_valid = 1'b1; chk_deq = 1'b1;
        e_deq_data = (m_bytes.size() > 0) ? m_bytes.pop_front() : 8'h00;
      end else if (q_ack) begin
        e_grant[m_win] = 1'b1;
        m_ptr = m_win;
        m_bytes.push_back(m_qbyte);
      end
    end
  endtask

  // One clock: predict, advance, update the environment queue, compare.
  task automatic tick();
    logic [7:0] qd_pre;
    bit do_push, do_pop, do_clr;
    logic n_ack;
    model_step();
    qd_pre = q_data; do_clr = reset; do_push = 1'b0; do_pop = 1'b0; n_ack = 1'b0;
    if (!reset) begin
      if (q_enqueue && env_q.size() < DEPTH && (accept_all || $urandom_range(0, 7) != 0)) begin
        do_push = 1'b1; n_ack = 1'b1;
      end
      do_pop = q_dequeue;
    end
    @(posedge clk_10khz); #1;
    if (do_clr) begin env_q.delete(); q_data_out = 8'h00; end
    if (do_push) env_q.push_back(qd_pre);
    if (do_pop) q_data_out = (env_q.size() > 0) ? env_q.pop_front() : 8'h00;
    q_ack = n_ack;
    upd_len();
    check("grant",     8'(req_grant), 8'(e_grant));
    check("deq_valid", 8'(deq_valid), 8'(e_deq_valid));
    check("q_enqueue", 8'(q_enqueue), 8'(e_q_enq));
    check("q_dequeue", 8'(q_dequeue), 8'(e_q_deq));
    check("busy",      8'(busy),      8'(e_busy));
    check("excl",      8'(q_enqueue & q_dequeue), 8'h00);
    if (chk_qdata) check("q_data", q_data, e_q_data);
    if (chk_deq)   check("deq_data", deq_data, e_deq_data);
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; deq_req = 1'b0; accept_all = 1'b1; force_len = -1;
    upd_len();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int         gi[$];
    int         gc[$];
    logic [7:0] got[$];
    logic [7:0] seq;
    int         nops;
    bit         seen;
    logic [N-1:0] pend;
    bit         dpend;

    reset = 1'b1; req_valid = '0; req_data = '0; deq_req = 1'b0;
    q_ack = 1'b0; q_data_out = 8'h00; upd_len();

    // Single producer, empty queue
    do_reset();
    req_valid = 4'b0001; req_data = 32'h0000_005A;
    tick(); check("s1_enq", 8'(q_enqueue), 8'h01); check("s1_data", q_data, 8'h5A);
    tick(); check("s1_nogrant", 8'(req_grant), 8'h00);
    tick(); check("s1_grant", 8'(req_grant), 8'h01);
    req_valid = '0;
    tick();

    // All four requesting continuously
    do_reset();
    req_valid = 4'hF; req_data = 32'h4433_2211;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (req_grant != '0) begin gi.push_back($clog2(req_grant)); gc.push_back(c); end
    end
    req_valid = '0;
    check("rr_count", 8'(gi.size()), 8'd5);
    for (int i = 0; i < gi.size(); i++) begin
`ifdef QARB_FIXED_PRIO0_EN
      check("rr_order", 8'(gi[i]), 8'd0);
`else
      check("rr_order", 8'(gi[i]), 8'(i % N));
`endif
      if (i > 0) check("rr_spacing", 8'(gc[i] - gc[i-1]), 8'd3);
    end
    tick();

    // Full queue blocks enqueue until space appears
    do_reset();
    force_len = 8; upd_len();
    req_valid = 4'b0010; req_data = 32'h0000_BB00;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen = seen | q_enqueue | (|req_grant);
    end
    check("full_blocks", 8'(seen), 8'h00);
    force_len = 7; upd_len();
    tick(); check("space_enq", 8'(q_enqueue), 8'h01);
    tick(); tick(); check("space_grant", 8'(req_grant), 8'h02);
    req_valid = '0; force_len = -1; upd_len();
    tick();

    // Enqueue 0x11, 0x22 then read them back in order
    do_reset();
    req_valid = 4'b0001; req_data = 32'h0000_0011;
    tick(); tick(); tick();
    req_data = 32'h0000_0022;
    tick(); tick(); tick();
    req_valid = '0; deq_req = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (deq_valid) got.push_back(deq_data);
      if (got.size() == 2) deq_req = 1'b0;
    end
    check("deq_count", 8'(got.size()), 8'd2);
    if (got.size() == 2) begin
      check("deq_first", got[0], 8'h11);
      check("deq_second", got[1], 8'h22);
    end

    // Both pending after reset: dequeue first, then alternate
    do_reset();
    env_q.push_back(8'hA1); env_q.push_back(8'hA2);
    m_bytes.push_back(8'hA1); m_bytes.push_back(8'hA2);
    upd_len();
    req_valid = 4'b0001; req_data = 32'h0000_0033; deq_req = 1'b1;
    seq = 8'h00; nops = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (q_dequeue || q_enqueue) begin seq = {seq[6:0], q_dequeue}; nops++; end
    end
    req_valid = '0; deq_req = 1'b0;
    check("alt_nops", 8'(nops), 8'd4);
    check("alt_seq", seq, 8'b0000_1010);

    // Reset during ENQ_WAIT aborts without a grant and restores the pointer
    do_reset();
    req_valid = 4'b0100; req_data = 32'h00CC_0000;
    tick(); tick(); tick(); check("r_grant2", 8'(req_grant), 8'h04);
    req_valid = 4'b0010; req_data = 32'h0000_DD00;
    tick(); tick(); check("r_busy_wait", 8'(busy), 8'h01);
    reset = 1'b1;
    tick(); check("r_nogrant", 8'(req_grant), 8'h00); check("r_idle", 8'(busy), 8'h00);
    reset = 1'b0; req_valid = 4'hF;
    tick(); tick(); tick(); check("r_first0", 8'(req_grant), 8'h01);

    // Randomized traffic against the model
    do_reset();
    accept_all = 1'b0; pend = '0; dpend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (e_grant[k]) pend[k] = 1'b0;
        else if (pend[k] && $urandom_range(0, 19) == 0) pend[k] = 1'b0;
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          pend[k] = 1'b1;
          req_data[k*8 +: 8] = 8'($urandom);
        end
      end
      req_valid = pend;
      if (e_deq_valid) dpend = 1'b0;
      if (!dpend && $urandom_range(0, 2) == 0) dpend = 1'b1;
      deq_req = dpend;
      reset = ($urandom_range(0, 149) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/queue_arbiter.md
QUEUE_ARBITER -- requirements
Module: queue_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of producer requesters (2..8).
REQ-002 Parameter: DEPTH, 8, capacity of the attached queue; q_len equal to DEPTH means full.
REQ-003 Port: clk_10khz  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  N_REQ  per-producer enqueue request; the producer holds it until granted.
REQ-006 Port: req_data  input  N_REQ*8  producer k byte at bits [8k+7:8k].
REQ-007 Port: req_grant  output  N_REQ  one-hot, 1-cycle pulse; the producer's byte was accepted.
REQ-008 Port: deq_req  input  1  consumer read request; held until deq_valid.
REQ-009 Port: deq_valid  output  1  1-cycle pulse; deq_data is valid.
REQ-010 Port: deq_data  output  8  byte removed from the queue.
REQ-011 Port: q_enqueue, q_dequeue  output  1 each  drive the queue's enqueue/dequeue inputs.
REQ-012 Port: q_data  output  8  byte presented to the queue's data input.
REQ-013 Port: q_ack  input  1  queue accept flag, registered one cycle after enqueue.
REQ-014 Port: q_len  input  4  queue occupancy, 0..DEPTH.
REQ-015 Port: q_data_out  input  8  queue read data, registered one cycle after dequeue.
REQ-016 Port: busy  output  1  high in every state except IDLE.

Function
REQ-017 States SHALL be IDLE, ENQ, ENQ_WAIT, DEQ and DEQ_WAIT; every non-IDLE state SHALL last exactly one cycle.
REQ-018 IDLE: an enqueue is eligible when any req_valid bit is set and q_len<DEPTH; a dequeue is eligible when deq_req=1 and q_len>0.
REQ-019 If both are eligible, the arbiter SHALL serve the opposite of the last served kind, tracked by toggle last_was_deq (reset 0, so the dequeue goes first); otherwise it SHALL serve the eligible one.
REQ-020 Enqueue selection SHALL be round-robin, searching from rr_ptr+1 modulo N_REQ; the winner index SHALL be latched on the IDLE->ENQ transition.
REQ-021 ENQ SHALL assert q_enqueue=1 with q_data=req_data[winner], then go to ENQ_WAIT.
REQ-022 ENQ_WAIT: if q_ack=1, pulse req_grant[winner] and set rr_ptr=winner.
REQ-023 ENQ_WAIT: if q_ack=0, issue no grant and leave rr_ptr unchanged; the producer retries.
REQ-024 ENQ_WAIT SHALL always return to IDLE.
REQ-025 DEQ SHALL assert q_dequeue=1 for one cycle; DEQ_WAIT SHALL register deq_data=q_data_out, pulse deq_valid and return to IDLE.
REQ-026 q_enqueue and q_dequeue SHALL never be high in the same cycle.
REQ-027 Minimum turnaround SHALL be 3 cycles per operation (IDLE->op->WAIT->IDLE).
REQ-028 A req_valid bit dropped before its grant SHALL be tolerated; the granted byte is the one sampled in ENQ.
REQ-029 With q_len=DEPTH, no enqueue SHALL start; with q_len=0, no dequeue SHALL start, and deq_req stays pending.

Reset
REQ-030 On reset=1 at a clock edge: state=IDLE and rr_ptr=N_REQ-1, so requester 0 is first.
REQ-031 On the same edge: last_was_deq=0, latched winner=0, and all outputs (req_grant, deq_valid, deq_data, q_enqueue, q_dequeue, q_data, busy) =0.
REQ-032 Reset asserted mid-operation SHALL abort it with no grant or deq_valid pulse issued.

Configuration
REQ-033 With QARB_FIXED_PRIO0_EN defined, requester 0 SHALL win whenever req_valid[0]=1; the remaining requesters are arbitrated round-robin.
REQ-034 Without QARB_FIXED_PRIO0_EN, pure round-robin SHALL apply to all N_REQ requesters.

Structure
REQ-035 Package queue_arbiter_pkg SHALL hold the state enum type, DATA_W=8 and the default DEPTH.
REQ-036 Sub-module rr_picker SHALL implement the rotating priority encoder (inputs req, ptr; outputs one-hot pick and index).

Verification
REQ-037 Single producer, queue empty: req_valid=0001 and req_data=0x5A -> q_enqueue pulse with q_data=0x5A, then req_grant=0001 two cycles later.
REQ-038 All four requesting continuously, queue never full -> grants in order 0,1,2,3,0; one grant every 3 cycles.
REQ-039 q_len=8 with req_valid=0010 -> no q_enqueue and no grant; drop q_len to 7 -> grant follows.
REQ-040 Queue holds 0x11,0x22, deq_req=1 -> deq_valid twice, with deq_data 0x11 then 0x22.
REQ-041 Enqueue and dequeue both pending after reset -> DEQ first, then ENQ, alternating.
REQ-042 Reset asserted in ENQ_WAIT -> no req_grant, busy=0 and rr_ptr=3 on the next cycle.
